// File: rtl/data_memory_sized.sv
// MEM-stage data memory with MIPS sub-word loads/stores, registered read data,
// and fault detection/bookkeeping for misaligned or out-of-range accesses.
module data_memory_sized #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_BITS = 10,
  parameter string       INIT_FILE = ""
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        AccessFault,
  output logic [31:0] FaultAddr,
  output logic [15:0] FaultCount
);

  logic [31:0]          mem_q [DEPTH];

  logic [ADDR_BITS-1:0] widx;
  logic [1:0]           off;
  logic                 in_range;
  logic                 size_fault;
  logic                 req;
  logic                 fault;
  logic                 do_load;
  logic                 do_store;
  logic [3:0]           be;
  logic [31:0]          wlanes;
  logic [31:0]          rword;
  logic [7:0]           rbyte;
  logic [15:0]          rhalf;
  logic [31:0]          ld_val;

  logic [31:0]          read_data_q,    read_data_d;
  logic                 read_valid_q,   read_valid_d;
  logic                 access_fault_q, access_fault_d;
  logic [31:0]          fault_addr_q,   fault_addr_d;
  logic [15:0]          fault_count_q,  fault_count_d;

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  always_comb begin
    widx       = Address[ADDR_BITS+1:2];
    off        = Address[1:0];
    in_range   = ({2'b00, Address[31:2]} < 32'(DEPTH));
    size_fault = (Size == 2'b11) ||
                 (Size == 2'b01 && Address[0]) ||
                 (Size == 2'b10 && Address[1:0] != 2'b00);
    req        = MemRead || MemWrite;
    fault      = req && (size_fault || !in_range);
    do_store   = !Rst && MemWrite && !fault;
    do_load    = !Rst && MemRead && !MemWrite;

    // Big-endian lanes: offset 0 is bits [31:24].
    case (Size)
      2'b00:   begin be = 4'b1000 >> off;             wlanes = {4{WriteData[7:0]}};  end
      2'b01:   begin be = off[1] ? 4'b0011 : 4'b1100; wlanes = {2{WriteData[15:0]}}; end
      default: begin be = 4'b1111;                    wlanes = WriteData;            end
    endcase

    rword = in_range ? mem_q[widx] : '0;
    case (off)
      2'd0:    rbyte = rword[31:24];
      2'd1:    rbyte = rword[23:16];
      2'd2:    rbyte = rword[15:8];
      default: rbyte = rword[7:0];
    endcase
    rhalf = off[1] ? rword[15:0] : rword[31:16];

    case (Size)
      2'b00:   ld_val = Unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   ld_val = Unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: ld_val = rword;
    endcase
  end

  always_comb begin
    read_data_d    = read_data_q;
    read_valid_d   = do_load;
    access_fault_d = !Rst && fault;
    fault_addr_d   = fault_addr_q;
    fault_count_d  = fault_count_q;
    if (do_load) read_data_d = fault ? '0 : ld_val;
    if (!Rst && fault) begin
      if (fault_count_q == '0) fault_addr_d  = Address;
      if (fault_count_q != '1) fault_count_d = fault_count_q + 16'd1;
    end
    if (Rst) begin
      read_data_d   = '0;
      fault_addr_d  = '0;
      fault_count_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    read_data_q    <= read_data_d;
    read_valid_q   <= read_valid_d;
    access_fault_q <= access_fault_d;
    fault_addr_q   <= fault_addr_d;
    fault_count_q  <= fault_count_d;
  end

  always_ff @(posedge Clk) begin
    if (do_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign ReadData    = read_data_q;
  assign ReadValid   = read_valid_q;
  assign AccessFault = access_fault_q;
  assign FaultAddr   = fault_addr_q;
  assign FaultCount  = fault_count_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: per-cycle expectations are queued when a
// request is driven and popped/compared one cycle later against the DUT outputs.
module tb_data_memory_sized;

    localparam int unsigned DEPTH = 16;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        AccessFault;
    logic [31:0] FaultAddr;
    logic [15:0] FaultCount;

    typedef struct {
        logic        valid;
        logic        fault;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    data_memory_sized #(.DEPTH(DEPTH), .ADDR_BITS(4), .INIT_FILE("")) dut (
        .Clk(Clk), .Rst(Rst), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size), .Unsigned(Unsigned),
        .ReadData(ReadData), .ReadValid(ReadValid), .AccessFault(AccessFault),
        .FaultAddr(FaultAddr), .FaultCount(FaultCount)
    );

    // One clock cycle: drive a request, queue what the outputs must show after the edge.
    task automatic step(input string tag, input logic rst, input logic wr, input logic rd,
                        input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, input logic ev, input logic ef,
                        input logic [31:0] ed);
        exp_t e;
        Rst = rst; MemWrite = wr; MemRead = rd; Size = sz; Unsigned = uns;
        Address = addr; WriteData = wd;
        exp_q.push_back('{valid: ev, fault: ef, data: ed});
        @(posedge Clk);
        #1;
        Rst = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (ReadValid === e.valid) else begin
                errors++;
                $error("FAIL %s ReadValid: got %b expected %b", tag, ReadValid, e.valid);
            end
            checks++;
            assert (AccessFault === e.fault) else begin
                errors++;
                $error("FAIL %s AccessFault: got %b expected %b", tag, AccessFault, e.fault);
            end
            checks++;
            assert (ReadData === e.data) else begin
                errors++;
                $error("FAIL %s ReadData: got %h expected %h", tag, ReadData, e.data);
            end
        end
    endtask

    task automatic check_fault(input string tag, input logic [31:0] ea, input logic [15:0] ec);
        checks++;
        assert (FaultAddr === ea) else begin
            errors++;
            $error("FAIL %s FaultAddr: got %h expected %h", tag, FaultAddr, ea);
        end
        checks++;
        assert (FaultCount === ec) else begin
            errors++;
            $error("FAIL %s FaultCount: got %0d expected %0d", tag, FaultCount, ec);
        end
    endtask

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

    initial begin
        Rst = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; Size = W; Unsigned = 1'b0;
        Address = '0; WriteData = '0;

        step("reset",      1, 0, 0, W, 0, 32'h0,  32'h0,        0, 0, 32'h0);
        check_fault("reset", 32'h0, 16'd0);

        // Word store then load, one-cycle latency, then valid drops.
        step("sw0",        0, 1, 0, W, 0, 32'h0,  32'h12345678, 0, 0, 32'h0);
        step("lw0",        0, 0, 1, W, 0, 32'h0,  32'h0,        1, 0, 32'h12345678);
        step("idle_hold",  0, 0, 0, W, 0, 32'h0,  32'h0,        0, 0, 32'h12345678);

        // Byte loads, sign and zero extension.
        step("lbu1",       0, 0, 1, B, 1, 32'h1,  32'h0,        1, 0, 32'h00000034);
        step("sw4",        0, 1, 0, W, 0, 32'h4,  32'h0000FFFF, 0, 0, 32'h00000034);
        step("lb7",        0, 0, 1, B, 0, 32'h7,  32'h0,        1, 0, 32'hFFFFFFFF);
        step("lbu7",       0, 0, 1, B, 1, 32'h7,  32'h0,        1, 0, 32'h000000FF);
        step("lb4",        0, 0, 1, B, 0, 32'h4,  32'h0,        1, 0, 32'h00000000);

        // Halfword loads.
        step("sw8",        0, 1, 0, W, 0, 32'h8,  32'hFFFF8001, 0, 0, 32'h00000000);
        step("lh10",       0, 0, 1, H, 0, 32'hA,  32'h0,        1, 0, 32'hFFFF8001);
        step("lhu10",      0, 0, 1, H, 1, 32'hA,  32'h0,        1, 0, 32'h00008001);
        step("lh8",        0, 0, 1, H, 0, 32'h8,  32'h0,        1, 0, 32'hFFFFFFFF);

        // Sub-word stores touch only their lanes; back-to-back store/load.
        step("sw12",       0, 1, 0, W, 0, 32'hC,  32'h0,        0, 0, 32'hFFFFFFFF);
        step("sb13",       0, 1, 0, B, 0, 32'hD,  32'h123456AB, 0, 0, 32'hFFFFFFFF);
        step("lw12_a",     0, 0, 1, W, 0, 32'hC,  32'h0,        1, 0, 32'h00AB0000);
        step("sh14",       0, 1, 0, H, 0, 32'hE,  32'h9999BEEF, 0, 0, 32'h00AB0000);
        step("lw12_b",     0, 0, 1, W, 0, 32'hC,  32'h0,        1, 0, 32'h00ABBEEF);

        // Faults: misaligned load, out-of-range store, odd halfword, reserved size.
        step("lw_mis",     0, 0, 1, W, 0, 32'h16, 32'h0,        1, 1, 32'h0);
        check_fault("lw_mis", 32'h16, 16'd1);
        step("sw_oor",     0, 1, 0, W, 0, 32'h40, 32'hDEADBEEF, 0, 1, 32'h0);
        check_fault("sw_oor", 32'h16, 16'd2);
        step("lw0_keep",   0, 0, 1, W, 0, 32'h0,  32'h0,        1, 0, 32'h12345678);
        step("lh_odd",     0, 0, 1, H, 0, 32'h9,  32'h0,        1, 1, 32'h0);
        step("sz_rsv",     0, 1, 0, R, 0, 32'h0,  32'h0,        0, 1, 32'h0);
        step("lw_noreq",   0, 0, 0, W, 0, 32'h3,  32'h0,        0, 0, 32'h0);
        check_fault("faults4", 32'h16, 16'd4);

        // Read+write together: store wins, no load.
        step("rw0",        0, 1, 1, W, 0, 32'h0,  32'hCAFEF00D, 0, 0, 32'h0);
        step("lw0_rw",     0, 0, 1, W, 0, 32'h0,  32'h0,        1, 0, 32'hCAFEF00D);

        // Load completes on the reset cycle; reset drops its own write.
        step("lw_prerst",  0, 0, 1, W, 0, 32'h8,  32'h0,        1, 0, 32'hFFFF8001);
        step("rst_wr",     1, 1, 0, W, 0, 32'h0,  32'h1,        0, 0, 32'h0);
        check_fault("rst_wr", 32'h0, 16'd0);
        step("lw0_postrst",0, 0, 1, W, 0, 32'h0,  32'h0,        1, 0, 32'hCAFEF00D);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
